multi_tick_timer: RTL and testbench

//  Parametrised multi-channel slow-clock and timer block for game timing.
//  A shared prescaler divides clk into a base tick (normal or turbo rate).
//  N_CH independent channels count base ticks down from a runtime period,
//  in periodic or one-shot mode. Each channel drives a tick pulse, a duty50

---
 rtl/tick_timer_pkg.sv | 15 +
 rtl/multi_tick_timer_if.sv | 29 ++
 rtl/tick_channel.sv | 84 ++++++++
 rtl/multi_tick_timer.sv | 71 +++++++
 tb/tb_multi_tick_timer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the multi-channel tick timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/multi_tick_timer_if.sv
// Control/status bundle between game logic (master) and the tick timer (slave).
// Latency: n/a (wires only).
// Backpressure: none; every signal is sampled or driven every clk.
interface multi_tick_timer_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic                    turbo;
    logic                    pause;
    logic [N_CH-1:0]         start;
    logic [N_CH-1:0]         mode;
    logic [N_CH*CNT_W-1:0]   period;
    logic                    base_tick;
    logic [N_CH-1:0]         tick;
    logic [N_CH-1:0]         duty50;
    logic [N_CH-1:0]         running;
    logic [N_CH-1:0]         done;
    logic [N_CH*CNT_W-1:0]   remaining;

    modport master (
        output turbo, pause, start, mode, period,
        input  base_tick, tick, duty50, running, done, remaining
    );

    modport slave (
        input  turbo, pause, start, mode, period,
        output base_tick, tick, duty50, running, done, remaining
    );
endinterface

// File: rtl/tick_channel.sv
// One timer channel: counts base ticks down from period, periodic or one-shot.
// Latency: tick/duty50/done/remaining registered, one clk after the base_tick they respond to.
// Backpressure: none; start is honoured every clk and always wins over base_tick.
module tick_channel
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             base_tick,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    output logic             tick,
    output logic             duty50,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] reload;
    logic             tick_q, tick_d;
    logic             duty_q, duty_d;
    logic             done_q, done_d;

    // A zero period would never expire, so it behaves as one tick per base tick.
    assign reload = (period == '0) ? CNT_W'(1) : period;

    // State and all channel outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tick_q  <= 1'b0;
            duty_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
        end
    end

    // Next state: start re-arms from any state; only RUN reacts to base_tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tick_d  = 1'b0;
        duty_d  = duty_q;
        done_d  = done_q;
        if (start) begin
            state_d = RUN;
            rem_d   = reload;
            duty_d  = 1'b0;
            done_d  = 1'b0;
        end else if (state_q == RUN && base_tick) begin
            if (rem_q > CNT_W'(1)) begin
                rem_d = rem_q - 1'b1;
            end else begin
                tick_d = 1'b1;
                duty_d = ~duty_q;
                if (mode == MODE_ONESHOT) begin
                    rem_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = reload;
                end
            end
        end
    end

    assign tick      = tick_q;
    assign duty50    = duty_q;
    assign done      = done_q;
    assign remaining = rem_q;
    assign running   = (state_q == RUN);

endmodule

// File: rtl/multi_tick_timer.sv
// Shared prescaler producing base_tick, feeding N_CH independent countdown channels.
// Latency: base_tick registered; first pulse LIM clks after reset release, channel outputs one clk later.
// Backpressure: none; pause freezes the prescaler, start is never blocked.
module multi_tick_timer
    import tick_timer_pkg::*;
#(
    parameter int BASE_CYCLES = 15000000,
    parameter int TURBO_DIV   = 10,
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    multi_tick_timer_if.slave   bus
);

    localparam int PW        = (BASE_CYCLES > 1) ? $clog2(BASE_CYCLES) : 1;
    localparam int LIM_T_RAW = BASE_CYCLES / TURBO_DIV;
    localparam int LIM_T     = (LIM_T_RAW < 1) ? 1 : LIM_T_RAW;
    localparam logic [PW-1:0] TOP_N = PW'(BASE_CYCLES - 1);
    localparam logic [PW-1:0] TOP_T = PW'(LIM_T - 1);

    logic [PW-1:0]       pre_cnt;
    logic [PW-1:0]       pre_top;
    logic                base_tick_q;
    logic [N_CH-1:0]     tick_v, duty_v, run_v, done_v;
    logic [N_CH*CNT_W-1:0] rem_v;

    // The >= compare lets a count already past a freshly lowered limit fire at once.
    assign pre_top = bus.turbo ? TOP_T : TOP_N;

    // Prescaler: wrap at the limit and emit a one-clk base_tick; pause holds the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt     <= '0;
            base_tick_q <= 1'b0;
        end else if (bus.pause) begin
            base_tick_q <= 1'b0;
        end else if (pre_cnt >= pre_top) begin
            pre_cnt     <= '0;
            base_tick_q <= 1'b1;
        end else begin
            pre_cnt     <= pre_cnt + 1'b1;
            base_tick_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .base_tick (base_tick_q),
            .start     (bus.start[i]),
            .mode      (bus.mode[i]),
            .period    (bus.period[i*CNT_W +: CNT_W]),
            .tick      (tick_v[i]),
            .duty50    (duty_v[i]),
            .running   (run_v[i]),
            .done      (done_v[i]),
            .remaining (rem_v[i*CNT_W +: CNT_W])
        );
    end

    assign bus.base_tick = base_tick_q;
    assign bus.tick      = tick_v;
    assign bus.duty50    = duty_v;
    assign bus.running   = run_v;
    assign bus.done      = done_v;
    assign bus.remaining = rem_v;

endmodule

// File: tb/tb_multi_tick_timer.sv
// Directed bench for multi_tick_timer with a cycle-level reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Literal expectations pin pulse spacing, one-shot status and reset behaviour.
module tb_multi_tick_timer;

    localparam int BASE = 20;
    localparam int TD   = 10;
    localparam int N    = 4;
    localparam int W    = 8;

    logic clk;
    logic reset;

    multi_tick_timer_if #(.N_CH(N), .CNT_W(W)) bus ();

    multi_tick_timer #(
        .BASE_CYCLES (BASE),
        .TURBO_DIV   (TD),
        .N_CH        (N),
        .CNT_W       (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Counts in plain integers: prescaler position, ticks left per channel.
    int  m_cnt;
    bit  m_bt;
    int  m_rem  [N];
    bit  m_tick [N];
    bit  m_duty [N];
    bit  m_done [N];
    bit  m_run  [N];
    int  m_per;
    int  m_lim;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0;
            m_bt  = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_rem[i] = 0; m_tick[i] = 0; m_duty[i] = 0; m_done[i] = 0; m_run[i] = 0;
            end
        end else begin
            // channels react to the base tick that was visible during the cycle
            for (int i = 0; i < N; i++) begin
                m_per = int'(bus.period[i*W +: W]);
                if (m_per == 0) m_per = 1;
                m_tick[i] = 1'b0;
                if (bus.start[i]) begin
                    m_rem[i] = m_per; m_duty[i] = 0; m_done[i] = 0; m_run[i] = 1;
                end else if (m_run[i] && m_bt) begin
                    if (m_rem[i] > 1) begin
                        m_rem[i] = m_rem[i] - 1;
                    end else begin
                        m_tick[i] = 1'b1;
                        m_duty[i] = !m_duty[i];
                        if (bus.mode[i]) begin
                            m_rem[i] = 0; m_done[i] = 1; m_run[i] = 0;
                        end else begin
                            m_rem[i] = m_per;
                        end
                    end
                end
            end
            m_lim = bus.turbo ? BASE / TD : BASE;
            if (bus.pause) begin
                m_bt = 1'b0;
            end else if (m_cnt + 1 >= m_lim) begin
                m_bt = 1'b1; m_cnt = 0;
            end else begin
                m_bt = 1'b0; m_cnt = m_cnt + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0]   e_tick, e_duty, e_run, e_done;
    logic [N*W-1:0] e_rem;

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                e_tick[i] = m_tick[i];
                e_duty[i] = m_duty[i];
                e_run[i]  = m_run[i];
                e_done[i] = m_done[i];
                e_rem[i*W +: W] = W'(m_rem[i]);
            end
            chk("model_base_tick", 64'(bus.base_tick), 64'(m_bt));
            chk("model_tick",      64'(bus.tick),      64'(e_tick));
            chk("model_duty50",    64'(bus.duty50),    64'(e_duty));
            chk("model_running",   64'(bus.running),   64'(e_run));
            chk("model_done",      64'(bus.done),      64'(e_done));
            chk("model_remaining", 64'(bus.remaining), 64'(e_rem));
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_bt(input int bound, output int n);
        n = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            n++;
            if (bus.base_tick) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_base_tick timeout after %0d cycles", bound);
    endtask

    task automatic wait_tick(input int ch, input int bound, output int n);
        n = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            n++;
            if (bus.tick[ch]) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_tick ch%0d timeout after %0d cycles", ch, bound);
    endtask

    // ---------------- directed stimulus ----------------
    int n, nbt, ntk, r0;
    bit same, prev;

    initial begin
        reset      = 1'b1;
        bus.turbo  = 1'b0;
        bus.pause  = 1'b0;
        bus.start  = '0;
        bus.mode   = '0;
        bus.period = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_base_tick", 64'(bus.base_tick), 64'd0);
        chk("rst_tick",      64'(bus.tick),      64'd0);
        chk("rst_running",   64'(bus.running),   64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_remaining", 64'(bus.remaining), 64'd0);
        reset = 1'b0;

        // 1. prescaler spacing, normal then turbo
        wait_bt(100, n); chk("bt_first_cycle", 64'(n), 64'd20);
        wait_bt(100, n); chk("bt_period_norm", 64'(n), 64'd20);
        bus.turbo = 1'b1;
        wait_bt(100, n); chk("bt_turbo_first", 64'(n), 64'd2);
        wait_bt(100, n); chk("bt_turbo_period", 64'(n), 64'd2);
        bus.turbo = 1'b0;

        // 2. ch0 periodic, period 3
        bus.mode[0] = 1'b0;
        bus.period[0 +: W] = 8'd3;
        bus.start[0] = 1'b1;
        @(negedge clk);
        bus.start[0] = 1'b0;
        chk("ch0_rem_after_start", 64'(bus.remaining[0 +: W]), 64'd3);
        chk("ch0_running", 64'(bus.running[0]), 64'd1);
        wait_tick(0, 200, n);
        chk("ch0_duty_after_tick1", 64'(bus.duty50[0]), 64'd1);
        wait_tick(0, 200, n);
        chk("ch0_tick_interval", 64'(n), 64'd60);
        chk("ch0_duty_after_tick2", 64'(bus.duty50[0]), 64'd0);

        // 3. ch1 one-shot, period 5
        bus.mode[1] = 1'b1;
        bus.period[W +: W] = 8'd5;
        bus.start[1] = 1'b1;
        @(negedge clk);
        bus.start[1] = 1'b0;
        wait_tick(1, 300, n);
        chk("ch1_done", 64'(bus.done[1]), 64'd1);
        chk("ch1_not_running", 64'(bus.running[1]), 64'd0);
        chk("ch1_rem_zero", 64'(bus.remaining[W +: W]), 64'd0);
        ntk = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.tick[1]) ntk++;
        end
        chk("ch1_no_more_ticks", 64'(ntk), 64'd0);
        chk("ch1_done_sticky", 64'(bus.done[1]), 64'd1);
        bus.start[1] = 1'b1;
        @(negedge clk);
        bus.start[1] = 1'b0;
        chk("ch1_rearm_done", 64'(bus.done[1]), 64'd0);
        chk("ch1_rearm_running", 64'(bus.running[1]), 64'd1);
        chk("ch1_rearm_rem", 64'(bus.remaining[W +: W]), 64'd5);

        // 4. pause for 50 clk at prescaler count 7
        wait_bt(100, n);
        repeat (7) @(negedge clk);
        bus.pause = 1'b1;
        r0 = int'(bus.remaining[0 +: W]);
        nbt = 0;
        same = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.base_tick) nbt++;
            if (int'(bus.remaining[0 +: W]) != r0) same = 1'b0;
        end
        chk("pause_no_base_tick", 64'(nbt), 64'd0);
        chk("pause_rem_frozen", 64'(same), 64'd1);
        bus.pause = 1'b0;
        wait_bt(100, n);
        chk("pause_resume_residual", 64'(n), 64'd13);

        // 5. turbo switch at prescaler count 15
        repeat (15) @(negedge clk);
        bus.turbo = 1'b1;
        @(negedge clk); chk("turbo_switch_fire", 64'(bus.base_tick), 64'd1);
        @(negedge clk); chk("turbo_switch_gap",  64'(bus.base_tick), 64'd0);
        @(negedge clk); chk("turbo_switch_next", 64'(bus.base_tick), 64'd1);

        // 6a. start coincident with base_tick on a channel about to expire
        bus.mode[2] = 1'b0;
        bus.period[2*W +: W] = 8'd1;
        bus.start[2] = 1'b1;
        @(negedge clk);
        bus.start[2] = 1'b0;
        repeat (6) @(negedge clk);
        wait_bt(20, n);
        bus.period[2*W +: W] = 8'd4;
        bus.start[2] = 1'b1;
        @(negedge clk);
        bus.start[2] = 1'b0;
        chk("coincide_no_tick", 64'(bus.tick[2]), 64'd0);
        chk("coincide_rem", 64'(bus.remaining[2*W +: W]), 64'd4);

        // 6b. period 0 behaves as 1: one tick per base tick
        bus.mode[3] = 1'b0;
        bus.period[3*W +: W] = 8'd0;
        bus.start[3] = 1'b1;
        @(negedge clk);
        bus.start[3] = 1'b0;
        prev = bus.base_tick;
        nbt = 0;
        ntk = 0;
        repeat (40) begin
            @(negedge clk);
            if (prev) nbt++;
            if (bus.tick[3]) ntk++;
            prev = bus.base_tick;
        end
        chk("p0_base_ticks", 64'(nbt), 64'd20);
        chk("p0_ticks_match", 64'(ntk), 64'(nbt));

        // 6c. asynchronous reset mid-run
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_base_tick", 64'(bus.base_tick), 64'd0);
        chk("arst_tick",      64'(bus.tick),      64'd0);
        chk("arst_duty50",    64'(bus.duty50),    64'd0);
        chk("arst_running",   64'(bus.running),   64'd0);
        chk("arst_done",      64'(bus.done),      64'd0);
        chk("arst_remaining", 64'(bus.remaining), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.turbo = 1'b0;
        bus.start = 4'b0001;
        @(negedge clk);
        bus.start = '0;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
